// File: rtl/atm_pin_auth_if.sv
// Signal bundle between the ATM PIN controller and the card session:
// card reader, keypad, account lookup, session timer and transaction side.
interface atm_pin_auth_if #(
    parameter int PIN_DIGITS = 4,
    parameter int TRY_W      = 2
);
    logic                    card_in;
    logic                    digit_valid;
    logic [3:0]              digit;
    logic                    enter;
    logic                    cancel;
    logic [4*PIN_DIGITS-1:0] stored_pin;
    logic                    timeout;
    logic                    timer_start;
    logic                    timer_restart;
    logic                    auth_ok;
    logic                    pin_fail;
    logic                    card_eject;
    logic                    card_retained;
    logic [TRY_W-1:0]        attempts_left;

    modport slave (
        input  card_in, digit_valid, digit, enter, cancel, stored_pin, timeout,
        output timer_start, timer_restart, auth_ok, pin_fail, card_eject,
               card_retained, attempts_left
    );

    modport master (
        output card_in, digit_valid, digit, enter, cancel, stored_pin, timeout,
        input  timer_start, timer_restart, auth_ok, pin_fail, card_eject,
               card_retained, attempts_left
    );
endinterface

// File: rtl/atm_pin_auth.sv
// PIN-entry and verification controller: collects keypad digits, checks them
// against the account PIN, drives the session timer and ejects or retains the card.
module atm_pin_auth #(
    parameter int PIN_DIGITS = 4,
    parameter int MAX_TRIES  = 3,
    parameter int TRY_W      = 2
) (
    input  logic           clk,
    input  logic           rst,
    atm_pin_auth_if.slave  bus
);
    localparam int PIN_W = 4 * PIN_DIGITS;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTER  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_FAIL   = 3'd3,
        ST_AUTH   = 3'd4,
        ST_EJECT  = 3'd5,
        ST_LOCKED = 3'd6
    } state_t;

    state_t             state_r, state_s;
    logic [PIN_W-1:0]   pin_buf_r, pin_buf_s;
    logic [CNT_W-1:0]   digit_cnt_r, digit_cnt_s;
    logic [TRY_W-1:0]   attempts_r, attempts_s;
    logic               timeout_q_r;
    logic               timeout_ev_s;
    logic               timer_restart_s, pin_fail_s;
    logic               timer_start_r, timer_restart_r, auth_ok_r;
    logic               pin_fail_r, card_eject_r, card_retained_r;

    // A sticky timeout only counts on its rising edge.
    assign timeout_ev_s = bus.timeout & ~timeout_q_r;

    // Next-state, PIN buffer, attempt counter and pulse outputs.
    always_comb begin
        state_s         = state_r;
        pin_buf_s       = pin_buf_r;
        digit_cnt_s     = digit_cnt_r;
        attempts_s      = attempts_r;
        timer_restart_s = 1'b0;
        pin_fail_s      = 1'b0;
        if ((state_r != ST_IDLE) && !bus.card_in) begin
            state_s     = ST_IDLE;
            pin_buf_s   = '0;
            digit_cnt_s = '0;
            attempts_s  = TRY_W'(MAX_TRIES);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.card_in) begin
                        state_s         = ST_ENTER;
                        timer_restart_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ENTER: begin
                    if (bus.cancel || timeout_ev_s) begin
                        state_s = ST_EJECT;
                    end else if (bus.enter) begin
                        state_s = ST_CHECK;
                    end else if (bus.digit_valid && (bus.digit <= 4'd9) &&
                                 (digit_cnt_r < CNT_W'(PIN_DIGITS))) begin
                        pin_buf_s       = (pin_buf_r << 4) | {{(PIN_W-4){1'b0}}, bus.digit};
                        digit_cnt_s     = digit_cnt_r + CNT_W'(1);
                        timer_restart_s = 1'b1;
                    end else begin
                        state_s = ST_ENTER;
                    end
                end
                ST_CHECK: begin
                    // A short entry never matches, so it costs an attempt.
                    if ((digit_cnt_r == CNT_W'(PIN_DIGITS)) && (pin_buf_r == bus.stored_pin)) begin
                        state_s = ST_AUTH;
                    end else begin
                        attempts_s = attempts_r - TRY_W'(1);
                        if (attempts_s == '0) begin
                            state_s = ST_LOCKED;
                        end else begin
                            state_s         = ST_FAIL;
                            pin_fail_s      = 1'b1;
                            timer_restart_s = 1'b1;
                        end
                    end
                end
                ST_FAIL: begin
                    state_s     = ST_ENTER;
                    pin_buf_s   = '0;
                    digit_cnt_s = '0;
                end
                ST_AUTH: begin
                    if (bus.cancel || timeout_ev_s) begin
                        state_s = ST_EJECT;
                    end else begin
                        state_s = ST_AUTH;
                    end
                end
                ST_EJECT:  state_s = ST_EJECT;
                ST_LOCKED: state_s = ST_LOCKED;
                default: begin
                    state_s     = ST_IDLE;
                    pin_buf_s   = '0;
                    digit_cnt_s = '0;
                    attempts_s  = TRY_W'(MAX_TRIES);
                end
            endcase
        end
    end

    // State, datapath and registered outputs derived from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            pin_buf_r       <= '0;
            digit_cnt_r     <= '0;
            attempts_r      <= TRY_W'(MAX_TRIES);
            timeout_q_r     <= 1'b0;
            timer_start_r   <= 1'b0;
            timer_restart_r <= 1'b0;
            auth_ok_r       <= 1'b0;
            pin_fail_r      <= 1'b0;
            card_eject_r    <= 1'b0;
            card_retained_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            pin_buf_r       <= pin_buf_s;
            digit_cnt_r     <= digit_cnt_s;
            attempts_r      <= attempts_s;
            timeout_q_r     <= bus.timeout;
            timer_start_r   <= (state_s == ST_ENTER) || (state_s == ST_CHECK) ||
                               (state_s == ST_FAIL)  || (state_s == ST_AUTH);
            timer_restart_r <= timer_restart_s;
            auth_ok_r       <= (state_s == ST_AUTH);
            pin_fail_r      <= pin_fail_s;
            card_eject_r    <= (state_s == ST_EJECT);
            card_retained_r <= (state_s == ST_LOCKED);
        end
    end

    assign bus.timer_start   = timer_start_r;
    assign bus.timer_restart = timer_restart_r;
    assign bus.auth_ok       = auth_ok_r;
    assign bus.pin_fail      = pin_fail_r;
    assign bus.card_eject    = card_eject_r;
    assign bus.card_retained = card_retained_r;
    assign bus.attempts_left = attempts_r;
endmodule

// File: tb/tb_atm_pin_auth.sv
// Directed self-checking bench for atm_pin_auth: one task per scenario,
// expected values worked out by hand from the controller's behaviour.
module tb_atm_pin_auth;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   restart_cnt;
    int   fail_cnt;
    int   base_r;
    int   base_f;

    atm_pin_auth_if #(.PIN_DIGITS(4), .TRY_W(2)) bus ();

    atm_pin_auth #(.PIN_DIGITS(4), .MAX_TRIES(3), .TRY_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        restart_cnt = 0;
        fail_cnt    = 0;
    end

    always @(negedge clk) begin
        if (bus.timer_restart) restart_cnt++;
        if (bus.pin_fail) fail_cnt++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic dig(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        step();
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
    endtask

    task automatic ent;
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
    endtask

    task automatic pin4(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) dig(p[i*4 +: 4]);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.card_in = 1'b0; bus.digit_valid = 1'b0; bus.digit = 4'd0;
        bus.enter = 1'b0; bus.cancel = 1'b0; bus.timeout = 1'b0;
        bus.stored_pin = 16'h1234;
        step(); step();
        total++; if (bus.attempts_left !== 2'd3) begin bad++; $display("FAIL reset_attempts got=%0d exp=3", bus.attempts_left); end
        total++; if ({bus.timer_start, bus.timer_restart, bus.auth_ok, bus.pin_fail, bus.card_eject, bus.card_retained} !== 6'b0)
            begin bad++; $display("FAIL reset_outputs got=%b exp=000000", {bus.timer_start, bus.timer_restart, bus.auth_ok, bus.pin_fail, bus.card_eject, bus.card_retained}); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_correct_pin;
        base_r = restart_cnt;
        bus.card_in = 1'b1;
        step();
        total++; if (bus.timer_restart !== 1'b1) begin bad++; $display("FAIL insert_restart got=%b exp=1", bus.timer_restart); end
        pin4(16'h1234);
        ent();
        total++; if (bus.auth_ok !== 1'b0) begin bad++; $display("FAIL check_cycle_auth got=%b exp=0", bus.auth_ok); end
        step();
        total++; if (bus.auth_ok !== 1'b1) begin bad++; $display("FAIL correct_auth got=%b exp=1", bus.auth_ok); end
        total++; if (restart_cnt - base_r !== 5) begin bad++; $display("FAIL restart_count got=%0d exp=5", restart_cnt - base_r); end
        total++; if (bus.attempts_left !== 2'd3) begin bad++; $display("FAIL correct_attempts got=%0d exp=3", bus.attempts_left); end
        total++; if (bus.timer_start !== 1'b1) begin bad++; $display("FAIL auth_timer_start got=%b exp=1", bus.timer_start); end
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        total++; if ({bus.card_eject, bus.auth_ok, bus.timer_start} !== 3'b100) begin bad++; $display("FAIL cancel_eject got=%b exp=100", {bus.card_eject, bus.auth_ok, bus.timer_start}); end
        bus.card_in = 1'b0;
        step();
        total++; if (bus.card_eject !== 1'b0) begin bad++; $display("FAIL removed_eject got=%b exp=0", bus.card_eject); end
    endtask

    task automatic test_wrong_then_right;
        bus.card_in = 1'b1;
        step();
        base_f = fail_cnt;
        pin4(16'h1235);
        ent();
        step();
        total++; if (bus.pin_fail !== 1'b1) begin bad++; $display("FAIL wrong_pin_fail got=%b exp=1", bus.pin_fail); end
        total++; if (bus.attempts_left !== 2'd2) begin bad++; $display("FAIL wrong_attempts got=%0d exp=2", bus.attempts_left); end
        step();
        total++; if (bus.pin_fail !== 1'b0) begin bad++; $display("FAIL pin_fail_pulse got=%b exp=0", bus.pin_fail); end
        pin4(16'h1234);
        ent();
        step();
        total++; if (bus.auth_ok !== 1'b1) begin bad++; $display("FAIL retry_auth got=%b exp=1", bus.auth_ok); end
        total++; if (bus.attempts_left !== 2'd2) begin bad++; $display("FAIL retry_attempts got=%0d exp=2", bus.attempts_left); end
        total++; if (fail_cnt - base_f !== 1) begin bad++; $display("FAIL pin_fail_cycles got=%0d exp=1", fail_cnt - base_f); end
        bus.card_in = 1'b0;
        step();
    endtask

    task automatic test_lockout;
        bus.card_in = 1'b1;
        step();
        pin4(16'h1235);
        ent();
        step();
        total++; if (bus.attempts_left !== 2'd2) begin bad++; $display("FAIL lock_att1 got=%0d exp=2", bus.attempts_left); end
        step();
        dig(4'd1); dig(4'd2);
        ent();
        step();
        total++; if ({bus.attempts_left, bus.pin_fail} !== 3'b011) begin bad++; $display("FAIL short_entry got=%b exp=011", {bus.attempts_left, bus.pin_fail}); end
        step();
        pin4(16'h9999);
        ent();
        step();
        total++; if ({bus.card_retained, bus.attempts_left, bus.timer_start, bus.pin_fail} !== 5'b10000)
            begin bad++; $display("FAIL locked got=%b exp=10000", {bus.card_retained, bus.attempts_left, bus.timer_start, bus.pin_fail}); end
        pin4(16'h1234);
        ent();
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        step();
        total++; if ({bus.card_retained, bus.auth_ok, bus.card_eject} !== 3'b100) begin bad++; $display("FAIL locked_keys got=%b exp=100", {bus.card_retained, bus.auth_ok, bus.card_eject}); end
        bus.card_in = 1'b0;
        step();
        total++; if ({bus.card_retained, bus.attempts_left} !== 3'b011) begin bad++; $display("FAIL unlock got=%b exp=011", {bus.card_retained, bus.attempts_left}); end
    endtask

    task automatic test_timeout;
        bus.card_in = 1'b1;
        step();
        dig(4'd1); dig(4'd2);
        bus.timeout = 1'b1;
        step();
        total++; if ({bus.card_eject, bus.timer_start} !== 2'b10) begin bad++; $display("FAIL timeout_eject got=%b exp=10", {bus.card_eject, bus.timer_start}); end
        bus.card_in = 1'b0;
        step();
        bus.card_in = 1'b1;
        step(); step(); step();
        total++; if ({bus.card_eject, bus.timer_start} !== 2'b01) begin bad++; $display("FAIL sticky_timeout got=%b exp=01", {bus.card_eject, bus.timer_start}); end
        bus.timeout = 1'b0;
        step();
        bus.timeout = 1'b1;
        step();
        total++; if (bus.card_eject !== 1'b1) begin bad++; $display("FAIL retimeout got=%b exp=1", bus.card_eject); end
        bus.timeout = 1'b0;
        bus.card_in = 1'b0;
        step();
    endtask

    task automatic test_priority;
        bus.card_in = 1'b1;
        step();
        dig(4'hA);
        total++; if (bus.timer_restart !== 1'b0) begin bad++; $display("FAIL bad_digit_restart got=%b exp=0", bus.timer_restart); end
        pin4(16'h1234);
        dig(4'd5);
        total++; if (bus.timer_restart !== 1'b0) begin bad++; $display("FAIL fifth_digit_restart got=%b exp=0", bus.timer_restart); end
        ent();
        step();
        total++; if (bus.auth_ok !== 1'b1) begin bad++; $display("FAIL ignored_digits_auth got=%b exp=1", bus.auth_ok); end
        bus.card_in = 1'b0;
        step();
        bus.card_in = 1'b1;
        step();
        dig(4'd1);
        bus.cancel = 1'b1; bus.enter = 1'b1;
        step();
        bus.cancel = 1'b0; bus.enter = 1'b0;
        total++; if ({bus.card_eject, bus.auth_ok} !== 2'b10) begin bad++; $display("FAIL cancel_over_enter got=%b exp=10", {bus.card_eject, bus.auth_ok}); end
        bus.card_in = 1'b0;
        step();
        bus.card_in = 1'b1;
        step();
        dig(4'd1); dig(4'd2); dig(4'd3);
        bus.digit_valid = 1'b1; bus.digit = 4'd4; bus.enter = 1'b1;
        step();
        bus.digit_valid = 1'b0; bus.digit = 4'd0; bus.enter = 1'b0;
        total++; if (bus.timer_restart !== 1'b0) begin bad++; $display("FAIL enter_over_digit_restart got=%b exp=0", bus.timer_restart); end
        step();
        total++; if ({bus.pin_fail, bus.attempts_left, bus.auth_ok} !== 4'b1100) begin bad++; $display("FAIL digit_dropped got=%b exp=1100", {bus.pin_fail, bus.attempts_left, bus.auth_ok}); end
        bus.card_in = 1'b0;
        step();
    endtask

    task automatic test_async_reset;
        bus.card_in = 1'b1;
        step();
        pin4(16'h1234);
        ent();
        step();
        total++; if (bus.auth_ok !== 1'b1) begin bad++; $display("FAIL pre_reset_auth got=%b exp=1", bus.auth_ok); end
        #3;
        rst = 1'b0;
        #1;
        total++; if ({bus.auth_ok, bus.timer_start, bus.card_eject, bus.attempts_left} !== 5'b00011)
            begin bad++; $display("FAIL async_reset got=%b exp=00011", {bus.auth_ok, bus.timer_start, bus.card_eject, bus.attempts_left}); end
        #2;
        rst = 1'b1;
        step();
        total++; if ({bus.timer_start, bus.timer_restart} !== 2'b11) begin bad++; $display("FAIL resume_enter got=%b exp=11", {bus.timer_start, bus.timer_restart}); end
        pin4(16'h1234);
        ent();
        step();
        total++; if (bus.auth_ok !== 1'b1) begin bad++; $display("FAIL resume_auth got=%b exp=1", bus.auth_ok); end
        bus.card_in = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_correct_pin();
        test_wrong_then_right();
        test_lockout();
        test_timeout();
        test_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
